emif_reset_sequencer: RTL and testbench

- Sits between the LPDDR2 EMIF status outputs and the system-wide reset input of the Nios V platform.
- Owns three jobs:
  - pulses the EMIF reset;
  - qualifies calibration (init_done and cal_success must be stable, cal_fail is watched);
  - releases the system reset only once LPDDR2 is proven good.
- Retries calibration a bounded number of times, then latches a fatal flag for debug/LED.

---
 rtl/emif_rstseq_pkg.sv | 30 +++
 rtl/emif_rstseq_sync.sv | 27 ++
 rtl/emif_reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_emif_reset_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/emif_rstseq_pkg.sv
// Shared definitions for the LPDDR2 EMIF reset sequencer.
//   state_e   : FSM states; the encoding is exported on state_dbg
//   RETRY_W   : width of the retry counter
//   cnt_width : width of the shared cycle counter
package emif_rstseq_pkg;

  typedef enum logic [2:0] {
    StEmifRst = 3'd0,
    StWaitCal = 3'd1,
    StHold    = 3'd2,
    StRun     = 3'd3,
    StFail    = 3'd4,
    StFatal   = 3'd5
  } state_e;

  localparam int unsigned RETRY_W = 4;

  // The counter only has to reach (limit - 1) for the largest limit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/emif_rstseq_sync.sv
// Single-bit multi-flop synchroniser for asynchronous EMIF status lines.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output, SYNC_STAGES cycles of latency
module emif_rstseq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/emif_reset_sequencer.sv
// LPDDR2 EMIF reset sequencer: pulses the EMIF reset, qualifies calibration and
// releases the system reset only once memory is proven good. Failed calibration
// is retried MAX_RETRY times before a sticky fatal flag is raised.
//   clk, reset            : clock, asynchronous active-high reset
//   local_init_done       : EMIF init done (asynchronous)
//   local_cal_success     : EMIF calibration success (asynchronous)
//   local_cal_fail        : EMIF calibration fail (asynchronous)
//   emif_reset_n          : EMIF reset, active low
//   sys_reset_n           : system reset, active low, high only in RUN
//   mem_ready             : high only in RUN
//   cal_fatal             : sticky, retries exhausted
//   retry_count           : attempts consumed in the current bring-up
//   state_dbg             : current state encoding
//   led_heartbeat         : blink output, built only with EMIF_RSTSEQ_HEARTBEAT_EN
// Optional macro: EMIF_RSTSEQ_HEARTBEAT_EN adds an HB_BITS free-running blink counter.
module emif_reset_sequencer
  import emif_rstseq_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 64,
  parameter int unsigned CAL_TIMEOUT = 16777216,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HB_BITS     = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               local_init_done,
  input  logic               local_cal_success,
  input  logic               local_cal_fail,
  output logic               emif_reset_n,
  output logic               sys_reset_n,
  output logic               mem_ready,
  output logic               cal_fatal,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state_dbg,
  output logic               led_heartbeat
);

  localparam int unsigned CntW = cnt_width(RST_CYCLES, CAL_TIMEOUT, HOLD_CYCLES);
  localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] CalLast  = CntW'(CAL_TIMEOUT - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RetryMax = RETRY_W'(MAX_RETRY);

  logic init_s, succ_s, fail_s;

  emif_rstseq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_init (
    .clk_i(clk), .rst_i(reset), .d_i(local_init_done), .q_o(init_s)
  );
  emif_rstseq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_succ (
    .clk_i(clk), .rst_i(reset), .d_i(local_cal_success), .q_o(succ_s)
  );
  emif_rstseq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fail (
    .clk_i(clk), .rst_i(reset), .d_i(local_cal_fail), .q_o(fail_s)
  );

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               emif_q, sys_q, mem_q, fatal_q;
  logic               emif_d, sys_d, mem_d, fatal_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    retry_d = retry_q;
    unique case (state_q)
      StEmifRst: begin
        if (cnt_q == RstLast) state_d = StWaitCal;
      end
      StWaitCal: begin
        if (fail_s)                state_d = StFail;
        else if (init_s && succ_s) state_d = StHold;
        else if (cnt_q == CalLast) state_d = StFail;
      end
      StHold: begin
        if (fail_s) begin
          state_d = StFail;
        end else if (!(init_s && succ_s)) begin
          state_d = StWaitCal;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (fail_s || !init_s) state_d = StFail;
      end
      StFail: begin
        if (retry_q < RetryMax) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = StEmifRst;
        end else begin
          state_d = StFatal;
        end
      end
      StFatal: cnt_d = '0;
      default: state_d = StEmifRst;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Outputs are registered from the next state so they change on the
    // transition edge itself. FAIL keeps the EMIF out of reset so the reset
    // pulse is exactly the EMIF_RST dwell.
    emif_d  = (state_d != StEmifRst);
    sys_d   = (state_d == StRun);
    mem_d   = (state_d == StRun);
    fatal_d = fatal_q | (state_d == StFatal);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmifRst;
      cnt_q   <= '0;
      retry_q <= '0;
      emif_q  <= 1'b0;
      sys_q   <= 1'b0;
      mem_q   <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      emif_q  <= emif_d;
      sys_q   <= sys_d;
      mem_q   <= mem_d;
      fatal_q <= fatal_d;
    end
  end

  assign emif_reset_n = emif_q;
  assign sys_reset_n  = sys_q;
  assign mem_ready    = mem_q;
  assign cal_fatal    = fatal_q;
  assign retry_count  = retry_q;
  assign state_dbg    = state_q;

`ifdef EMIF_RSTSEQ_HEARTBEAT_EN
  logic [HB_BITS-1:0] hb_q;
  logic               led_q, led_d;

  always_comb begin
    led_d = 1'b0;
    if (state_d == StRun)        led_d = hb_q[HB_BITS-1];
    else if (state_d == StFatal) led_d = hb_q[HB_BITS-3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb_q  <= '0;
      led_q <= 1'b0;
    end else begin
      hb_q  <= hb_q + HB_BITS'(1);
      led_q <= led_d;
    end
  end

  assign led_heartbeat = led_q;
`else
  logic unused_hb_bits;
  assign unused_hb_bits = ^HB_BITS;
  assign led_heartbeat  = 1'b0;
`endif

endmodule

// File: tb/tb_emif_reset_sequencer.sv
// Randomised scoreboard bench for emif_reset_sequencer. Stimulus pushes the
// expected (edge, outputs) events derived from the timing rules; a monitor pops
// one entry whenever the observable outputs change.
module tb_emif_reset_sequencer;

  localparam int unsigned RstC  = 8;
  localparam int unsigned CalT  = 100;
  localparam int unsigned HoldC = 16;
  localparam int unsigned MaxR  = 2;
  localparam int unsigned SyncS = 2;

  localparam int StR = 0, StW = 1, StH = 2, StRun = 3, StF = 4, StX = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_done = 1'b0, cal_success = 1'b0, cal_fail = 1'b0;
  logic       emif_reset_n, sys_reset_n, mem_ready, cal_fatal, led_heartbeat;
  logic [3:0] retry_count;
  logic [2:0] state_dbg;

  emif_reset_sequencer #(
    .RST_CYCLES(RstC), .CAL_TIMEOUT(CalT), .HOLD_CYCLES(HoldC),
    .MAX_RETRY(MaxR), .SYNC_STAGES(SyncS), .HB_BITS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .local_init_done(init_done), .local_cal_success(cal_success),
    .local_cal_fail(cal_fail),
    .emif_reset_n(emif_reset_n), .sys_reset_n(sys_reset_n), .mem_ready(mem_ready),
    .cal_fatal(cal_fatal), .retry_count(retry_count), .state_dbg(state_dbg),
    .led_heartbeat(led_heartbeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t edge=%0d)", name, got, exp,
               $time, cyc);
    end
  endtask

  // Output table: EMIF reset low only in EMIF_RST, system released only in RUN,
  // fatal flag only once FATAL is reached.
  function automatic logic [11:0] exp_obs(input int st, input int r);
    logic e, s, f;
    e = (st != StR);
    s = (st == StRun);
    f = (st == StX);
    return {e, s, s, f, 4'(r), 3'(st)};
  endfunction

  typedef struct {
    int          cyc;
    logic [11:0] o;
  } ev_t;
  ev_t exp_q[$];

  task automatic push(input int c, input int st, input int r);
    ev_t e;
    e.cyc = c;
    e.o   = exp_obs(st, r);
    exp_q.push_back(e);
  endtask

  // Monitor
  logic        mon_en = 1'b0;
  logic [11:0] prev = '0;
  always @(negedge clk) begin
    logic [11:0] cur;
    ev_t e;
    cur = {emif_reset_n, sys_reset_n, mem_ready, cal_fatal, retry_count, state_dbg};
    if (mon_en && cur !== prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", 32'(cur), 32'(prev));
      end else begin
        e = exp_q.pop_front();
        chk("event_edge", 32'(cyc), 32'(e.cyc));
        chk("event_outputs", 32'(cur), 32'(e.o));
      end
      prev = cur;
    end
  end

`ifdef EMIF_RSTSEQ_HEARTBEAT_EN
  logic hb_prev = 1'b0;
  logic in_run = 1'b0;
  int   last_tog = -1;
  always @(negedge clk) begin
    if (reset || state_dbg != 3'd3) begin
      in_run   = 1'b0;
      last_tog = -1;
    end else if (!in_run) begin
      in_run = 1'b1;
    end else if (led_heartbeat !== hb_prev) begin
      if (last_tog >= 0) chk("hb_period", 32'(cyc - last_tog), 32'd8);
      last_tog = cyc;
    end
    hb_prev = led_heartbeat;
  end
`else
  int hb_bad = 0;
  always @(negedge clk) if (led_heartbeat !== 1'b0) hb_bad++;
`endif

  task automatic goto_edge(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Asserts reset between clock edges, checks the asynchronous reset values
  // before the next edge, then releases on a falling edge.
  int base;
  task automatic do_reset();
    mon_en      = 1'b0;
    init_done   = 1'b0;
    cal_success = 1'b0;
    cal_fail    = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        32'({emif_reset_n, sys_reset_n, mem_ready, cal_fatal, retry_count, state_dbg}),
        32'(exp_obs(StR, 0)));
    chk("async_reset_led", 32'(led_heartbeat), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    prev   = exp_obs(StR, 0);
    base   = cyc;
    mon_en = 1'b1;
  endtask

  task automatic end_scenario(input int c);
    goto_edge(c);
    chk("events_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, e, k, f, h, g, l, r, t;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int it = 0; it < 3; it++) begin
      // Nominal bring-up followed by a calibration failure while running.
      do_reset();
      d = $urandom_range(10, 30);
      push(base + RstC, StW, 0);
      goto_edge(base + d);
      init_done = 1'b1;
      cal_success = 1'b1;
      e = base + d;
      push(e + SyncS + 1, StH, 0);
      push(e + SyncS + HoldC + 1, StRun, 0);
      k = $urandom_range(3, 20);
      f = e + SyncS + HoldC + 1 + k;
      goto_edge(f);
      cal_fail = 1'b1;
      push(f + SyncS + 1, StF, 0);
      push(f + SyncS + 2, StR, 1);
      push(f + SyncS + 2 + RstC, StW, 1);
      push(f + SyncS + 3 + RstC, StH, 1);
      push(f + SyncS + 3 + RstC + HoldC, StRun, 0);
      goto_edge(f + 4);
      cal_fail = 1'b0;
      end_scenario(f + 45);

      // Success glitch during HOLD.
      do_reset();
      d = $urandom_range(10, 30);
      push(base + RstC, StW, 0);
      goto_edge(base + d);
      init_done = 1'b1;
      cal_success = 1'b1;
      h = base + d + SyncS + 1;
      push(h, StH, 0);
      g = h + $urandom_range(2, 12);
      goto_edge(g);
      cal_success = 1'b0;
      push(g + SyncS + 1, StW, 0);
      l = $urandom_range(1, 4);
      r = g + l;
      goto_edge(r);
      cal_success = 1'b1;
      push(r + SyncS + 1, StH, 0);
      push(r + SyncS + HoldC + 1, StRun, 0);
      end_scenario(r + 30);

      // Never calibrates: timeouts, retries, then fatal.
      do_reset();
      init_done = 1'($urandom_range(0, 1));
      t = base;
      for (int a = 0; a <= int'(MaxR); a++) begin
        t += RstC;
        push(t, StW, a);
        t += CalT;
        push(t, StF, a);
        t += 1;
        if (a < int'(MaxR)) push(t, StR, a + 1);
        else push(t, StX, a);
      end
      end_scenario(t + 20);

      // Bring-up interrupted by reset in HOLD (reset check is in do_reset).
      do_reset();
      d = $urandom_range(10, 30);
      push(base + RstC, StW, 0);
      goto_edge(base + d);
      init_done = 1'b1;
      cal_success = 1'b1;
      h = base + d + SyncS + 1;
      push(h, StH, 0);
      end_scenario(h + $urandom_range(1, 14));
    end

    do_reset();
    end_scenario(base + 5);
`ifndef EMIF_RSTSEQ_HEARTBEAT_EN
    chk("led_tied_low", 32'(hb_bad), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
